four_chan_mux: RTL and testbench
================================

FOUR_CHAN_MUX -- requirements
Module: four_chan_mux

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data width of every channel.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; it SHALL be asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 4, per-channel valid; bit k belongs to channel k.
REQ-005 The block SHALL have port in_data, input, 4xDATA_W, per-channel data; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-006 The block SHALL have port in_ready, output, 4, per-channel accept strobe.
REQ-007 The block SHALL have port out_valid, output, 1, meaning the output register holds a word.
REQ-008 The block SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-009 The block SHALL have port out_data, output, DATA_W, the registered word.
REQ-010 The block SHALL have port out_sel0, output, 1, the source channel index bit 1 (MSB).
REQ-011 The block SHALL have port out_sel1, output, 1, the source channel index bit 0 (LSB).
REQ-012 The pair {out_sel0,out_sel1} SHALL equal the source channel index, so that it drives the existing 1:4 demux select inputs directly and routes the word back to its matching output y0..y3.

Function
REQ-013 Transfers SHALL follow valid/ready: a transfer occurs on a clock edge where valid and ready are both 1.
REQ-014 Once asserted, out_valid, out_data and the select outputs SHALL hold stable until out_ready is 1.
REQ-015 The block SHALL contain a two-state FSM over the output register, with states EMPTY and FULL.
REQ-016 The FSM SHALL define load_en = (state==EMPTY) | out_ready.
REQ-017 When load_en=1 and any in_valid bit is 1, exactly one channel SHALL be granted.
REQ-018 Channel selection SHALL be round-robin: the first valid channel found scanning upward from pointer ptr, modulo 4.
REQ-019 The block SHALL drive in_ready[k] = load_en & grant[k]; at most one bit of in_ready SHALL be 1 per cycle.
REQ-020 In_ready SHALL NOT depend on in_data.
REQ-021 On a grant, the block SHALL register the data and index of the granted channel into the output in the same edge.
REQ-022 On a grant, the FSM SHALL go to FULL.
REQ-023 On a grant, ptr SHALL become (granted index + 1) mod 4, wrapping 3 to 0.
REQ-024 When load_en=1 and no in_valid bit is 1, the FSM SHALL go to EMPTY if out_ready=1.
REQ-025 When load_en=1 and no in_valid bit is 1, ptr SHALL be unchanged.
REQ-026 In state FULL with out_ready=0, all in_ready bits SHALL be 0 and no state SHALL change.
REQ-027 In state FULL with out_ready=1 and a valid input, the output drain and the new load SHALL occur on the same edge, with no bubble.
REQ-028 Latency from input acceptance to out_valid SHALL be exactly 1 cycle.
REQ-029 Sustained throughput SHALL be 1 word/cycle when out_ready is held at 1.
REQ-030 With all four channels continuously valid, grants SHALL rotate 0,1,2,3,0...
REQ-031 No channel SHALL wait more than 3 grants while it is valid.
REQ-032 In_valid bits asserted in the same cycle as they are granted SHALL be honoured; there SHALL be no extra setup cycle.

Reset
REQ-033 While rst=1, the block SHALL hold out_valid=0, out_data=0, out_sel0=0, out_sel1=0, ptr=0, state=EMPTY and in_ready=0, regardless of clk.
REQ-034 Reset asserted mid-transfer SHALL discard the held word without emitting it.
REQ-035 The first grant after reset release SHALL start scanning at channel 0.

Structure
REQ-036 Package four_chan_mux_pkg SHALL hold NUM_CH=4, the 2-bit type chan_idx_t, and the state enum {EMPTY, FULL}.
REQ-037 The round-robin grant logic SHALL be one sub-module, rr_arbiter4, with inputs req[3:0], ptr and en, and outputs grant[3:0] (one-hot or zero) and the granted index.
REQ-038 Everything else, including the FSM, the output register and ptr, SHALL live in four_chan_mux.

Verification
REQ-039 Reset check: assert rst with in_valid=4'b1111 -> out_valid=0, in_ready=0 and out_data=0; release rst -> first grant goes to channel 0.
REQ-040 Single channel: drive only channel 2 with data 8'hA5 and out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_sel0=1, out_sel1=0.
REQ-041 Rotation: in_valid=4'b1111 with data 8'h10/8'h11/8'h12/8'h13 and out_ready=1 -> out_data sequence 10,11,12,13,10, one word per cycle.
REQ-042 Backpressure: load the word from channel 1, then hold out_ready=0 for 3 cycles -> output stable; in_ready=0; ptr unchanged; the word drains on the first cycle out_ready=1.
REQ-043 Wrap and skip: ptr=3 with in_valid=4'b0011 -> channel 0 granted, then channel 1.
REQ-044 End-to-end: connect out_sel0/out_sel1 and bit 0 of out_data to the existing 1:4 demux -> each channel's 1 appears only on the matching y0..y3.

Source files
------------

// File: rtl/four_chan_mux_pkg.sv
// rtl/four_chan_mux_pkg.sv - shared channel count, index type and output-register states
package four_chan_mux_pkg;
   localparam int NUM_CH = 4;

   typedef logic [1:0] chan_idx_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;
endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-way round-robin grant, scanning upward from ptr
module rr_arbiter4
   import four_chan_mux_pkg::*;
(
   input  logic [3:0] req,
   input  chan_idx_t  ptr,
   input  logic       en,
   output logic [3:0] grant,
   output chan_idx_t  idx
);

   logic      found;
   chan_idx_t cand;

   // First requester at or after ptr wins; the 2-bit add wraps 3 back to 0.
   always_comb begin
      grant = 4'b0000;
      idx   = ptr;
      found = 1'b0;
      cand  = ptr;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = ptr + chan_idx_t'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      if (found && en) begin
         grant[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/four_chan_mux.sv
// rtl/four_chan_mux.sv - four-channel round-robin mux into a single registered output
module four_chan_mux
   import four_chan_mux_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            in_valid,
   input  logic [4*DATA_W-1:0]   in_data,
   output logic [3:0]            in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_sel0,
   output logic                  out_sel1
);

   state_t    state;
   state_t    state_nxt;
   chan_idx_t ptr;
   chan_idx_t sel;
   chan_idx_t gnt_idx;
   logic [3:0] grant;
   logic       load_en;
   logic       take;

   // The register may accept a new word when it is empty or being drained this edge.
   assign load_en = (state == EMPTY) | out_ready;

   // Gating with rst keeps every in_ready low for the whole reset interval.
   rr_arbiter4 u_arb (
      .req   (in_valid),
      .ptr   (ptr),
      .en    (load_en & ~rst),
      .grant (grant),
      .idx   (gnt_idx)
   );

   assign take      = |grant;
   assign in_ready  = grant;
   assign out_valid = (state == FULL);
   assign out_sel0  = sel[1];
   assign out_sel1  = sel[0];

   // State register for the output word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // A grant fills the register; a load opportunity with nothing granted leaves it empty.
   always_comb begin
      state_nxt = state;
      if (take) begin
         state_nxt = FULL;
      end else if (load_en) begin
         state_nxt = EMPTY;
      end
   end

   // Capture granted word and its source, and move the pointer past the winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= '0;
         sel      <= '0;
         ptr      <= '0;
      end else if (take) begin
         out_data <= in_data[32'(gnt_idx) * DATA_W +: DATA_W];
         sel      <= gnt_idx;
         ptr      <= gnt_idx + 2'd1;
      end
   end

endmodule

// File: tb/tb_four_chan_mux.sv
// tb/tb_four_chan_mux.sv - randomized and directed checks of four_chan_mux against a reference model
module tb_four_chan_mux;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [3:0]     in_valid;
   logic [4*W-1:0] in_data;
   logic [3:0]     in_ready;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data;
   logic           out_sel0;
   logic           out_sel1;
   logic [3:0]     y;

   int vectors     = 0;
   int miscompares = 0;

   bit         m_full;
   logic [7:0] m_data;
   int         m_ch;
   int         m_ptr;

   four_chan_mux #(.DATA_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel0  (out_sel0),
      .out_sel1  (out_sel1)
   );

   always #5 clk = ~clk;

   // Downstream 1:4 demux: bit 0 of the word routed to y[{sel0,sel1}].
   assign y = (out_valid && out_data[0]) ? (4'b0001 << {out_sel0, out_sel1}) : 4'b0000;

   function automatic int m_pick(input logic [3:0] v);
      for (int i = 0; i < 4; i++) begin
         if (v[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
      end
      return -1;
   endfunction

   function automatic logic [3:0] m_ready(input logic [3:0] v, input logic r);
      int g;
      if (m_full && !r) return 4'b0000;
      g = m_pick(v);
      if (g < 0) return 4'b0000;
      return 4'b0001 << g;
   endfunction

   task automatic model_reset();
      m_full = 0;
      m_data = 8'h00;
      m_ch   = 0;
      m_ptr  = 0;
   endtask

   task automatic tick();
      int g;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (!m_full || out_ready) begin
         g = m_pick(in_valid);
         if (g >= 0) begin
            m_full = 1;
            m_data = in_data[g*W +: W];
            m_ch   = g;
            m_ptr  = (g + 1) % 4;
         end else begin
            m_full = 0;
         end
      end
      #1;
   endtask

   task automatic drive(input logic [3:0] v, input logic [4*W-1:0] d, input logic r);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(4'b0000, '0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(4'b1111, 32'h44332211, 1'b1);
      tick();
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vectors++;
      if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
      vectors++;
      if (out_data !== 8'h00 || {out_sel0, out_sel1} !== 2'b00) begin
         miscompares++; $display("FAIL reset_out_data got %h sel %b%b want 00 sel 00", out_data, out_sel0, out_sel1);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL reset_first_grant got %b want 0001", in_ready); end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'h11) begin
         miscompares++; $display("FAIL reset_first_word got v=%b d=%h want v=1 d=11", out_valid, out_data);
      end
   endtask

   task automatic test_single();
      do_reset();
      drive(4'b0100, 32'h00A50000, 1'b1);
      vectors++;
      if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL single_in_ready got %b want 0100", in_ready); end
      tick();
      drive(4'b0000, '0, 1'b1);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel0 !== 1'b1 || out_sel1 !== 1'b0) begin
         miscompares++;
         $display("FAIL single_out got v=%b d=%h sel=%b%b want v=1 d=a5 sel=10", out_valid, out_data, out_sel0, out_sel1);
      end
   endtask

   task automatic test_rotation();
      logic [7:0] exp;
      do_reset();
      drive(4'b1111, 32'h13121110, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         exp = 8'h10 + 8'(i % 4);
         vectors++;
         if (out_valid !== 1'b1 || out_data !== exp) begin
            miscompares++; $display("FAIL rotation_%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      drive(4'b0010, 32'h00005C00, 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(4'b1111, 32'hD3D2D1D0, 1'b0);
         vectors++;
         if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h5C || {out_sel0, out_sel1} !== 2'b01) begin
            miscompares++;
            $display("FAIL backpressure_%0d got rdy=%b v=%b d=%h sel=%b%b want rdy=0000 v=1 d=5c sel=01",
                     i, in_ready, out_valid, out_data, out_sel0, out_sel1);
         end
         tick();
      end
      drive(4'b1111, 32'hD3D2D1D0, 1'b1);
      vectors++;
      if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL backpressure_ptr got %b want 0100", in_ready); end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'hD2) begin
         miscompares++; $display("FAIL backpressure_drain got v=%b d=%h want v=1 d=d2", out_valid, out_data);
      end
   endtask

   task automatic test_wrap_skip();
      do_reset();
      drive(4'b0100, 32'h00770000, 1'b1);
      tick();
      drive(4'b0011, 32'h0000B1B0, 1'b1);
      vectors++;
      if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL wrap_grant0 got %b want 0001", in_ready); end
      tick();
      vectors++;
      if ({out_sel0, out_sel1} !== 2'b00 || out_data !== 8'hB0 || in_ready !== 4'b0010) begin
         miscompares++;
         $display("FAIL wrap_word0 got sel=%b%b d=%h rdy=%b want sel=00 d=b0 rdy=0010", out_sel0, out_sel1, out_data, in_ready);
      end
      tick();
      vectors++;
      if ({out_sel0, out_sel1} !== 2'b01 || out_data !== 8'hB1) begin
         miscompares++; $display("FAIL wrap_word1 got sel=%b%b d=%h want sel=01 d=b1", out_sel0, out_sel1, out_data);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(4'b1000, 32'h9E000000, 1'b0);
      tick();
      drive(4'b0000, '0, 1'b0);
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL midreset_load got v=%b want 1", out_valid); end
      rst = 1'b1;
      #1;
      model_reset();
      vectors++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 4'b0000) begin
         miscompares++; $display("FAIL midreset_async got v=%b d=%h rdy=%b want v=0 d=00 rdy=0000", out_valid, out_data, in_ready);
      end
      tick();
      rst = 1'b0;
      drive(4'b0000, '0, 1'b1);
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_discard got v=%b want 0", out_valid); end
   endtask

   task automatic test_demux();
      logic [4*W-1:0] d;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         d = '0;
         d[k*W] = 1'b1;
         drive(4'b0001 << k, d, 1'b1);
         tick();
         vectors++;
         if (y !== (4'b0001 << k)) begin
            miscompares++; $display("FAIL demux_ch%0d got y=%b want %b", k, y, 4'b0001 << k);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] exp_rdy;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         drive(4'($urandom), $urandom, ($urandom_range(0, 9) < 7));
         exp_rdy = m_ready(in_valid, out_ready);
         vectors++;
         if (in_ready !== exp_rdy) begin
            miscompares++; $display("FAIL rand_in_ready c=%0d got %b want %b", c, in_ready, exp_rdy);
         end
         vectors++;
         if (out_valid !== m_full) begin
            miscompares++; $display("FAIL rand_out_valid c=%0d got %b want %b", c, out_valid, m_full);
         end
         if (m_full) begin
            vectors++;
            if (out_data !== m_data || {out_sel0, out_sel1} !== 2'(m_ch)) begin
               miscompares++;
               $display("FAIL rand_word c=%0d got d=%h sel=%b%b want d=%h ch=%0d", c, out_data, out_sel0, out_sel1, m_data, m_ch);
            end
         end
         tick();
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 4'b0000;
      in_data   = '0;
      out_ready = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_rotation();
      test_backpressure();
      test_wrap_skip();
      test_reset_mid();
      test_demux();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
